// File: rtl/llr_fetch_pkg.sv
// Shared types and sizing for the LLR fetch path.
// Word packing, counts and FSM encoding.
package llr_fetch_pkg;

  localparam int LLR_WIDTH     = 8;
  localparam int WORDS_PER_MEM = 64;
  localparam int LLRS_PER_WORD = 4;
  localparam int NUM_MEMS      = 2;
  localparam int LLR_TOTAL     =
    NUM_MEMS * WORDS_PER_MEM * LLRS_PER_WORD;

  localparam int ADDR_W     = $clog2(WORDS_PER_MEM);
  localparam int SLOT_W     = $clog2(LLRS_PER_WORD);
  localparam int WORD_CNT_W = $clog2(NUM_MEMS * WORDS_PER_MEM);
  localparam int IDX_W      = $clog2(LLR_TOTAL);
  localparam int WORD_W     = LLR_WIDTH * LLRS_PER_WORD;

  // Slot s lives in bits [s*LLR_WIDTH +: LLR_WIDTH].
  typedef logic [LLRS_PER_WORD-1:0][LLR_WIDTH-1:0] llr_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } fetch_state_e;

endpackage

// File: rtl/llr_word_buffer.sv
// Two-entry word FIFO that hands out one LLR per pop.
// An entry frees when its last slot is popped.
module llr_word_buffer
  import llr_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  llr_word_t            push_data,
  input  logic                 pop,
  output logic [LLR_WIDTH-1:0] llr_data,
  output logic                 llr_valid,
  output logic                 word_free,
  output logic [1:0]           count
);

  llr_word_t mem_q [2];
  llr_word_t mem_d [2];
  logic wr_q, wr_d;
  logic rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic pop_ok;

  assign llr_valid = (cnt_q != 2'd0);
  assign pop_ok    = pop && llr_valid;
  assign word_free = pop_ok &&
    (slot_q == SLOT_W'(LLRS_PER_WORD - 1));
  assign llr_data  = llr_valid ? mem_q[rd_q][slot_q] : '0;
  assign count     = cnt_q;

  // Write on push, advance slot on pop, retire word on last slot.
  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    slot_d = slot_q;
    if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = ~wr_q;
    end
    if (pop_ok) begin
      slot_d = slot_q + 1'b1;
    end
    if (word_free) begin
      rd_d = ~rd_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, word_free};
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
      slot_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/llr_fetch.sv
// Reads both LLR RAMs after llr_done and streams
// the 512 LLRs in index order over valid/ready.
module llr_fetch
  import llr_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 llr_done,
  output logic [ADDR_W-1:0]    llr_mem_r_addr,
  output logic                 llr_mem_1_r_enable,
  output logic                 llr_mem_2_r_enable,
  input  logic [WORD_W-1:0]    llr_mem_1_r_data,
  input  logic [WORD_W-1:0]    llr_mem_2_r_data,
  output logic [LLR_WIDTH-1:0] llr_out,
  output logic [IDX_W-1:0]     llr_out_idx,
  output logic                 llr_out_valid,
  output logic                 llr_out_last,
  input  logic                 llr_out_ready,
  output logic                 busy,
  output logic                 fetch_done
);

  fetch_state_e state_q, state_d;
  logic [WORD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0] out_cnt_q, out_cnt_d;
  logic infl_q, infl_d;
  logic sel_q, sel_d;

  logic hs;
  logic issue;
  logic word_free;
  logic [1:0] buf_cnt;
  logic [1:0] occ;
  logic last_word;
  logic last_llr;
  llr_word_t push_data;

  // In-flight read counts against buffer space.
  assign occ = buf_cnt + {1'b0, infl_q};
  assign issue = (state_q == ST_FETCH) &&
    ((occ < 2'd2) || word_free);

  assign last_word = (rd_cnt_q ==
    WORD_CNT_W'(NUM_MEMS * WORDS_PER_MEM - 1));
  assign last_llr = (out_cnt_q == IDX_W'(LLR_TOTAL - 1));

  assign hs = llr_out_valid && llr_out_ready;

  // Top word-counter bit picks the RAM.
  assign llr_mem_1_r_enable = issue && !rd_cnt_q[WORD_CNT_W-1];
  assign llr_mem_2_r_enable = issue && rd_cnt_q[WORD_CNT_W-1];
  assign llr_mem_r_addr =
    issue ? rd_cnt_q[ADDR_W-1:0] : addr_q;

  assign push_data = sel_q ? llr_word_t'(llr_mem_2_r_data)
                           : llr_word_t'(llr_mem_1_r_data);

  assign llr_out_idx  = out_cnt_q;
  assign llr_out_last = llr_out_valid && last_llr;
  assign busy = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign fetch_done = (state_q == ST_DONE);

  llr_word_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst),
    .push      (infl_q),
    .push_data (push_data),
    .pop       (hs),
    .llr_data  (llr_out),
    .llr_valid (llr_out_valid),
    .word_free (word_free),
    .count     (buf_cnt)
  );

  // Next state, read address generation and output counting.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    addr_d    = addr_q;
    out_cnt_d = out_cnt_q;
    infl_d    = issue;
    sel_d     = issue ? rd_cnt_q[WORD_CNT_W-1] : sel_q;
    if (hs) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end
    if (issue) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      addr_d   = rd_cnt_q[ADDR_W-1:0];
    end
    unique case (state_q)
      ST_IDLE: begin
        if (llr_done) begin
          state_d   = ST_FETCH;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      ST_FETCH: begin
        if (issue && last_word) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (hs && last_llr) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      addr_q    <= '0;
      out_cnt_q <= '0;
      infl_q    <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      addr_q    <= addr_d;
      out_cnt_q <= out_cnt_d;
      infl_q    <= infl_d;
      sel_q     <= sel_d;
    end
  end

endmodule

// File: tb/tb_llr_fetch.sv
// Randomized bench for llr_fetch with RAM models
// and an index-order scoreboard.
module tb_llr_fetch;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic llr_done = 1'b0;
  logic llr_out_ready = 1'b0;
  logic [5:0] r_addr;
  logic en1, en2;
  logic [31:0] rd1 = '0;
  logic [31:0] rd2 = '0;
  logic [7:0] llr_out;
  logic [8:0] idx;
  logic valid, last, busy, fd;

  always #5 clk = ~clk;

  llr_fetch dut (
    .clk                (clk),
    .rst                (rst),
    .llr_done           (llr_done),
    .llr_mem_r_addr     (r_addr),
    .llr_mem_1_r_enable (en1),
    .llr_mem_2_r_enable (en2),
    .llr_mem_1_r_data   (rd1),
    .llr_mem_2_r_data   (rd2),
    .llr_out            (llr_out),
    .llr_out_idx        (idx),
    .llr_out_valid      (valid),
    .llr_out_last       (last),
    .llr_out_ready      (llr_out_ready),
    .busy               (busy),
    .fetch_done         (fd)
  );

  logic [31:0] ram1 [64];
  logic [31:0] ram2 [64];

  always @(posedge clk) begin
    if (en1) rd1 <= ram1[r_addr];
    if (en2) rd2 <= ram2[r_addr];
  end

  function automatic logic [7:0] ref_llr(int k);
    logic [31:0] w;
    int word;
    word = k / 4;
    w = (word < 64) ? ram1[word] : ram2[word - 64];
    return w[8*(k%4) +: 8];
  endfunction

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rmode = 0;

  int exp_k, hs_cnt, fd_cnt, rd_words, done_words;
  int first_valid_cyc, first_hs_cyc, last_hs_cyc;
  int fd_cyc, hs255, hs256;
  bit prev_stall;
  logic [7:0] p_out;
  logic [8:0] p_idx;
  logic p_last;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rmode == 0) llr_out_ready = 1'b1;
    else if (rmode == 1)
      llr_out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (valid !== 1'b1 || llr_out !== p_out ||
            idx !== p_idx || last !== p_last) begin
          fails++;
          $display("FAIL stall_hold: got v=%b d=%h k=%0d l=%b, need 1 %h %0d %b",
                   valid, llr_out, idx, last, p_out, p_idx, p_last);
        end
      end
      if (valid === 1'b1 && first_valid_cyc < 0)
        first_valid_cyc = cyc;
      if (valid === 1'b1 && llr_out_ready) begin
        checks++;
        if (idx !== 9'(exp_k) || llr_out !== ref_llr(exp_k) ||
            last !== (exp_k == 511)) begin
          fails++;
          $display("FAIL stream: got k=%0d d=%h l=%b, need k=%0d d=%h l=%b",
                   idx, llr_out, last, exp_k, ref_llr(exp_k),
                   exp_k == 511);
        end
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        if (exp_k == 255) hs255 = cyc;
        if (exp_k == 256) hs256 = cyc;
        if (exp_k % 4 == 3) done_words++;
        exp_k++;
        hs_cnt++;
      end
      checks++;
      if (en1 === 1'b1 && en2 === 1'b1) begin
        fails++;
        $display("FAIL strobe_both: got en1=%b en2=%b, need one", en1, en2);
      end
      if (en1 === 1'b1 || en2 === 1'b1) begin
        checks++;
        if ({en2, r_addr} !== 7'(rd_words) || rd_words >= 128) begin
          fails++;
          $display("FAIL read_order: got ram2=%b addr=%0d, need word %0d",
                   en2, r_addr, rd_words);
        end
        checks++;
        if (rd_words - done_words > 1) begin
          fails++;
          $display("FAIL overflow: got %0d words held, need <= 2",
                   rd_words - done_words + 1);
        end
        rd_words++;
      end
      if (fd === 1'b1) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      prev_stall = (valid === 1'b1) && !llr_out_ready;
      p_out = llr_out;
      p_idx = idx;
      p_last = last;
    end
  end

  task automatic sb_clear();
    exp_k = 0; hs_cnt = 0; fd_cnt = 0;
    rd_words = 0; done_words = 0;
    first_valid_cyc = -1; first_hs_cyc = -1;
    last_hs_cyc = -1; fd_cyc = -1;
    hs255 = -1; hs256 = -1;
  endtask

  task automatic fill_ramp();
    for (int a = 0; a < 64; a++) begin
      ram1[a] = {8'(4*a+3), 8'(4*a+2), 8'(4*a+1), 8'(4*a)};
      ram2[a] = {8'(4*a+3), 8'(4*a+2), 8'(4*a+1), 8'(4*a)};
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < 64; a++) begin
      ram1[a] = $urandom;
      ram2[a] = $urandom;
    end
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    llr_done = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    llr_done = 1'b0;
  endtask

  task automatic wait_fd(int budget);
    int n = 0;
    while (fd_cnt == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (fd_cnt == 0) begin
      fails++;
      $display("FAIL fetch_timeout: got no fetch_done in %0d, need one", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rmode = 0;
    sb_clear();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({r_addr, en1, en2, llr_out, idx, valid, last, busy, fd} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got a=%0d e=%b%b d=%h k=%0d v=%b l=%b b=%b f=%b, need 0",
               r_addr, en1, en2, llr_out, idx, valid, last, busy, fd);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_stream();
    fill_ramp();
    sb_clear();
    rmode = 0;
    pulse_done();
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b1 || en1 !== 1'b1 || en2 !== 1'b0 || r_addr !== 6'd0) begin
      fails++;
      $display("FAIL first_strobe: got b=%b e=%b%b a=%0d, need 1 10 0",
               busy, en1, en2, r_addr);
    end
    wait_fd(700);
    checks++;
    if (hs_cnt !== 512) begin
      fails++;
      $display("FAIL stream_count: got %0d, need 512", hs_cnt);
    end
    checks++;
    if (first_valid_cyc - start_cyc !== 3) begin
      fails++;
      $display("FAIL first_valid: got cycle %0d, need 3", first_valid_cyc - start_cyc);
    end
    checks++;
    if (last_hs_cyc - start_cyc !== 514) begin
      fails++;
      $display("FAIL last_hs: got cycle %0d, need 514", last_hs_cyc - start_cyc);
    end
    checks++;
    if (fd_cyc - start_cyc !== 515) begin
      fails++;
      $display("FAIL done_cycle: got cycle %0d, need 515", fd_cyc - start_cyc);
    end
    checks++;
    if (hs256 - hs255 !== 1) begin
      fails++;
      $display("FAIL ram_cross: got gap %0d, need 1", hs256 - hs255);
    end
    checks++;
    if (rd_words !== 128) begin
      fails++;
      $display("FAIL read_count: got %0d, need 128", rd_words);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || fd !== 1'b0 || fd_cnt !== 1) begin
      fails++;
      $display("FAIL done_pulse: got b=%b f=%b n=%0d, need 0 0 1", busy, fd, fd_cnt);
    end
  endtask

  task automatic test_random_ready();
    fill_random();
    sb_clear();
    rmode = 1;
    pulse_done();
    wait_fd(4000);
    rmode = 0;
    checks++;
    if (hs_cnt !== 512 || rd_words !== 128) begin
      fails++;
      $display("FAIL rand_count: got %0d llrs %0d words, need 512 128",
               hs_cnt, rd_words);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (fd_cnt !== 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rand_done: got n=%0d b=%b, need 1 0", fd_cnt, busy);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    fill_random();
    sb_clear();
    rmode = 2;
    llr_out_ready = 1'b0;
    pulse_done();
    while (valid !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (100) @(negedge clk);
    #1;
    checks++;
    if (rd_words !== 2) begin
      fail_reads: begin
        fails++;
        $display("FAIL stall_reads: got %0d, need 2", rd_words);
      end
    end
    checks++;
    if (valid !== 1'b1 || idx !== 9'd0 || llr_out !== ref_llr(0)) begin
      fails++;
      $display("FAIL stall_head: got v=%b k=%0d d=%h, need 1 0 %h",
               valid, idx, llr_out, ref_llr(0));
    end
    @(posedge clk); #1;
    llr_out_ready = 1'b1;
    rmode = 0;
    wait_fd(700);
    checks++;
    if (hs_cnt !== 512 || last_hs_cyc - first_hs_cyc !== 511) begin
      fails++;
      $display("FAIL stall_resume: got %0d llrs span %0d, need 512 511",
               hs_cnt, last_hs_cyc - first_hs_cyc);
    end
  endtask

  task automatic test_double_done();
    int n = 0;
    fill_ramp();
    sb_clear();
    rmode = 0;
    pulse_done();
    while (exp_k < 200 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    llr_done = 1'b1;
    @(posedge clk); #1;
    llr_done = 1'b0;
    wait_fd(700);
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (hs_cnt !== 512 || fd_cnt !== 1 || fd_cyc - start_cyc !== 515) begin
      fails++;
      $display("FAIL double_done: got %0d llrs %0d dones at %0d, need 512 1 515",
               hs_cnt, fd_cnt, fd_cyc - start_cyc);
    end
  endtask

  task automatic test_done_collision();
    int n = 0;
    fill_ramp();
    sb_clear();
    rmode = 0;
    pulse_done();
    while (cyc != start_cyc + 515 && n < 700) begin
      @(posedge clk); #1;
      n++;
    end
    llr_done = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (fd !== 1'b1) begin
      fails++;
      $display("FAIL collide_cycle: got fetch_done=%b, need 1", fd);
    end
    @(posedge clk); #1;
    llr_done = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || rd_words !== 128 || fd_cnt !== 1) begin
      fails++;
      $display("FAIL collide_ignored: got b=%b words=%0d dones=%0d, need 0 128 1",
               busy, rd_words, fd_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    fill_random();
    sb_clear();
    rmode = 0;
    pulse_done();
    while (exp_k < 300 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({r_addr, en1, en2, llr_out, idx, valid, last, busy, fd} !== '0) begin
      fails++;
      $display("FAIL mid_reset: got a=%0d e=%b%b d=%h k=%0d v=%b l=%b b=%b f=%b, need 0",
               r_addr, en1, en2, llr_out, idx, valid, last, busy, fd);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    sb_clear();
    repeat (3) @(posedge clk);
    pulse_done();
    @(negedge clk); #1;
    checks++;
    if (en1 !== 1'b1 || en2 !== 1'b0 || r_addr !== 6'd0) begin
      fail_restart: begin
        fails++;
        $display("FAIL restart_strobe: got e=%b%b a=%0d, need 10 0", en1, en2, r_addr);
      end
    end
    wait_fd(700);
    checks++;
    if (hs_cnt !== 512 || first_valid_cyc - start_cyc !== 3 || fd_cnt !== 1) begin
      fails++;
      $display("FAIL restart_stream: got %0d llrs first %0d dones %0d, need 512 3 1",
               hs_cnt, first_valid_cyc - start_cyc, fd_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_random_ready();
    test_stall();
    test_double_done();
    test_done_collision();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
